// File: rtl/s_axis.sv
// rtl/s_axis.sv - store-and-forward AXI4-Stream frame receiver with contiguous replay burst
// Optional feature macro: S_AXIS_LEN_CHECK_EN (adds sticky len_err output)
module s_axis #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 800
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tstrb,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  output logic                busy
`ifdef S_AXIS_LEN_CHECK_EN
  ,
  output logic                len_err
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic {RECV, SEND} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_wr_cnt;
  logic [CW-1:0]      r_rd_cnt;
  logic [CW-1:0]      r_frame_len;
  logic               r_tready;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic               r_out_last;
  logic [DATA_W-1:0]  r_mem [2**ADDR_W];

  logic               w_accept;
  logic               w_eof;
  logic               w_last_rd;
  logic               w_unused;

  // Byte strobes carry no information here: every beat is a full word.
  assign w_unused  = ^s_axis_tstrb;

  assign w_accept  = s_axis_tvalid & r_tready & (r_state == RECV);
  assign w_eof     = w_accept & (s_axis_tlast | (r_wr_cnt == C_LAST));
  assign w_last_rd = (r_state == SEND) & (r_rd_cnt == (r_frame_len - C_ONE));

  assign s_axis_tready = r_tready;
  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_last      = r_out_last;
  assign busy          = (r_state == SEND);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= RECV;
    else       r_state <= w_next;
  end

  // Next state: close the frame on the end-of-frame beat, return after the last read issues
  always_comb begin
    w_next = r_state;
    case (r_state)
      RECV: if (w_eof)     w_next = SEND;
      SEND: if (w_last_rd) w_next = RECV;
      default:             w_next = RECV;
    endcase
  end

  // Write/read counters and latched frame length; both counters clear when replay ends
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_frame_len <= '0;
    end else begin
      if (w_accept) r_wr_cnt <= r_wr_cnt + C_ONE;
      if (w_eof)    r_frame_len <= r_wr_cnt + C_ONE;
      if (r_state == SEND) begin
        if (w_last_rd) begin
          r_rd_cnt <= '0;
          r_wr_cnt <= '0;
        end else begin
          r_rd_cnt <= r_rd_cnt + C_ONE;
        end
      end
    end
  end

  // tready is held low one extra cycle after SEND so it re-opens only once the last word is out
  always_ff @(posedge clk) begin
    if (!rstn) r_tready <= 1'b0;
    else       r_tready <= (r_state == RECV) && (w_next == RECV);
  end

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_cnt[ADDR_W-1:0]] <= s_axis_tdata;
  end

  // Registered read: word issued in cycle t appears on out_data in t+1; data holds when idle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= (r_state == SEND);
      r_out_last  <= w_last_rd;
      if (r_state == SEND) r_out_data <= r_mem[r_rd_cnt[ADDR_W-1:0]];
    end
  end

`ifdef S_AXIS_LEN_CHECK_EN
  logic r_len_err;
  assign len_err = r_len_err;

  // Sticky flag: frame ended by tlast before full length, or reached full length without tlast
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_len_err <= 1'b0;
    end else if (w_eof && ((s_axis_tlast && (r_wr_cnt != C_LAST)) ||
                           ((r_wr_cnt == C_LAST) && !s_axis_tlast))) begin
      r_len_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_s_axis.sv
// tb/tb_s_axis.sv - self-checking bench for s_axis with a frame-level reference model
module tb_s_axis;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 10;
  localparam int FRAME_LEN = 800;

  logic                clk = 1'b0;
  logic                rstn;
  logic                s_axis_tvalid;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tstrb;
  logic                s_axis_tlast;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_last;
  logic                busy;
`ifdef S_AXIS_LEN_CHECK_EN
  logic                len_err;
`endif

  s_axis #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .busy(busy)
`ifdef S_AXIS_LEN_CHECK_EN
    , .len_err(len_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] cur[$];
  logic [DATA_W-1:0] exp_data[$];
  bit                exp_last[$];
  bit                exp_len_err = 0;
  int ov_start = 1, ov_end = 0, busy_until = 0;
  bit tr_en = 0;
  int n_out = 0, n_last = 0;
  logic [DATA_W-1:0] dval = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // An accepted beat in cycle c; a frame closes on tlast or on reaching FRAME_LEN words
  task automatic model_accept(input logic [DATA_W-1:0] d, input bit l, input int c);
    int len;
    cur.push_back(d);
    if (l || cur.size() == FRAME_LEN) begin
      len = cur.size();
      for (int k = 0; k < len; k++) begin
        exp_data.push_back(cur[k]);
        exp_last.push_back(k == len - 1);
      end
      if ((l && len != FRAME_LEN) || (len == FRAME_LEN && !l)) exp_len_err = 1;
      ov_start   = c + 2;
      ov_end     = c + 1 + len;
      busy_until = c + 2 + len;
      cur.delete();
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      if (out_last) n_last++;
      if (exp_data.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("out_data", out_data, exp_data.pop_front());
        chk("out_last", out_last, exp_last.pop_front());
      end
    end
    chk("out_valid_window", out_valid, (cyc >= ov_start && cyc <= ov_end));
    if (tr_en) begin
      chk("tready_window", s_axis_tready, (cyc >= busy_until));
      chk("busy_window", busy, (cyc >= ov_start - 1 && cyc < busy_until - 1));
    end
  end

  // Sends n accepted beats; while tready is low it drives junk with tvalid high
  task automatic send_frame(input int n, input bit tl, input int gap);
    int i = 0;
    bit acc;
    int c;
    while (i < n) begin
      if (!s_axis_tready) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'($urandom);
      end else begin
        s_axis_tvalid = ($urandom_range(0, 99) >= gap);
        s_axis_tdata  = dval;
        s_axis_tlast  = tl && (i == n - 1);
      end
      s_axis_tstrb = 4'($urandom);
      acc = s_axis_tvalid && s_axis_tready;
      c = cyc;
      @(posedge clk); #1;
      if (acc) begin
        model_accept(s_axis_tdata, s_axis_tlast, c);
        dval = dval + 1;
        i++;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_data.size() != 0 || cyc < busy_until) && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 5000) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int k);
    tr_en = 0;
    rstn  = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
`ifdef S_AXIS_LEN_CHECK_EN
    chk("rst_len_err", len_err, 0);
`endif
    cur.delete();
    exp_len_err = 0;
    rstn = 1'b1;
    busy_until = cyc + 1;
    tr_en = 1;
  endtask

  typedef struct {
    int n;
    bit tl;
    int gap;
    int exp_words;
    bit exp_err;
  } vec_t;

  vec_t tv[6];

  initial begin
    int o0, l0, c0;
    tv[0] = '{800, 1'b1, 0,  800, 1'b0};
    tv[1] = '{5,   1'b1, 0,  5,   1'b1};
    tv[2] = '{800, 1'b0, 0,  800, 1'b1};
    tv[3] = '{800, 1'b1, 50, 800, 1'b1};
    tv[4] = '{1,   1'b1, 30, 1,   1'b1};
    tv[5].n = $urandom_range(2, 799);
    tv[5].tl = 1'b1;
    tv[5].gap = $urandom_range(0, 70);
    tv[5].exp_words = tv[5].n;
    tv[5].exp_err = 1'b1;

    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    do_reset(3);
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      o0 = n_out; l0 = n_last;
      send_frame(tv[t].n, tv[t].tl, tv[t].gap);
      drain();
      chk($sformatf("vec%0d_words", t), n_out - o0, tv[t].exp_words);
      chk($sformatf("vec%0d_lasts", t), n_last - l0, 1);
`ifdef S_AXIS_LEN_CHECK_EN
      chk($sformatf("vec%0d_len_err", t), len_err, tv[t].exp_err);
      chk($sformatf("vec%0d_len_err_model", t), len_err, exp_len_err);
`endif
    end

    // Short frame timing with tvalid held high during SEND
    send_frame(5, 1'b1, 0);
    c0 = cyc;
    chk("short_tready_n1", s_axis_tready, 0);
    chk("short_busy_n1", busy, 1);
    chk("short_valid_n1", out_valid, 0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD_BEEF; s_axis_tlast = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("short_cycle_n6", cyc - c0, 5);
    chk("short_last_n6", out_last, 1);
    chk("short_tready_n6", s_axis_tready, 0);
    @(posedge clk); #1;
    chk("short_tready_n7", s_axis_tready, 1);
    chk("short_valid_n7", out_valid, 0);
    drain();

    // Reset in the middle of a frame discards it
    o0 = n_out;
    send_frame(300, 1'b0, 0);
    do_reset(2);
    @(posedge clk); #1;
    chk("midrst_no_output", n_out - o0, 0);
    send_frame(800, 1'b1, 0);
    drain();
    chk("midrst_words", n_out - o0, 800);

    // Back-to-back full frames
    o0 = n_out; l0 = n_last;
    send_frame(800, 1'b1, 0);
    send_frame(800, 1'b1, 0);
    drain();
    chk("b2b_words", n_out - o0, 1600);
    chk("b2b_lasts", n_last - l0, 2);
`ifdef S_AXIS_LEN_CHECK_EN
    chk("b2b_len_err", len_err, 0);
`endif
    chk("leftover_expected", exp_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
